// File: rtl/pipo_pkg.sv
// Shared definitions for the pipo_pipe register pipeline: default geometry,
// the occupancy-counter width function and the default-width stage layout.
package pipo_pkg;

    localparam int PIPO_DEF_WIDTH = 4;
    localparam int PIPO_DEF_DEPTH = 4;

    // Contents of one pipeline stage at the default word width. Modules built
    // for other widths keep the same field order: valid, parity, data.
    typedef struct packed {
        logic                      valid;
        logic                      par;
        logic [PIPO_DEF_WIDTH-1:0] data;
    } stage_t;

    // Bits needed to count 0..depth stored words (1 bit for depth 1).
    function automatic int cnt_w(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pipo_stage.sv
// One register stage of pipo_pipe with a valid/ready handshake.
// The stage accepts a new word whenever it is empty or its downstream neighbour
// accepts this cycle, so bubbles collapse. Flush clears valid but leaves the
// data register untouched. The parity bit exists only when PIPO_PARITY_EN is
// defined; otherwise par is constant 0.
module pipo_stage
    import pipo_pkg::*;
#(
    parameter int WIDTH = PIPO_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_par,
    input  logic             out_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             par,
    output logic             in_ready
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             load_word;

    assign in_ready  = !valid_q || out_ready;
    // Data only moves for a real word, so an output stage fed bubbles keeps its last value.
    assign load_word = in_ready && in_valid && !flush;

    // Next state: take the upstream word when ready, flush empties the stage.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (in_ready) begin
            valid_d = in_valid;
        end
        if (load_word) begin
            data_d = in_data;
        end
        if (flush) begin
            valid_d = 1'b0;
        end
    end

    // Stage registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid = valid_q;
    assign data  = data_q;

`ifdef PIPO_PARITY_EN
    logic par_q, par_d;

    // Parity travels with its word and is cleared by flush as well as clr.
    always_comb begin
        par_d = par_q;
        if (load_word) begin
            par_d = in_par;
        end
        if (flush) begin
            par_d = 1'b0;
        end
    end

    // Parity register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            par_q <= 1'b0;
        end else begin
            par_q <= par_d;
        end
    end

    assign par = par_q;
`else
    logic unused_in_par;

    assign unused_in_par = in_par;
    assign par           = 1'b0;
`endif

endmodule

// File: rtl/pipo_pipe.sv
// Multi-stage parallel-in/parallel-out pipeline: DEPTH pipo_stage instances
// chained by a combinational ready path, plus a registered occupancy count.
// Optional feature macro: PIPO_PARITY_EN adds a stored even-parity bit per
// word, reported on q_par; without it q_par is 0.
module pipo_pipe
    import pipo_pkg::*;
#(
    parameter int WIDTH = PIPO_DEF_WIDTH,
    parameter int DEPTH = PIPO_DEF_DEPTH
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic [WIDTH-1:0]          d,
    input  logic                      d_valid,
    output logic                      d_ready,
    input  logic                      flush,
    output logic [WIDTH-1:0]          q,
    output logic                      v,
    input  logic                      q_ready,
    output logic [cnt_w(DEPTH)-1:0]   count,
    output logic                      q_par
);

    localparam int CNT_W = cnt_w(DEPTH);

    if (DEPTH < 1) begin : g_depth_chk
        $error("pipo_pipe: DEPTH must be at least 1");
    end

    logic             stg_valid [DEPTH];
    logic [WIDTH-1:0] stg_data  [DEPTH];
    logic             stg_par   [DEPTH];
    logic             stg_rdy   [DEPTH+1];
    logic             head_par;
    logic             in_xfer;
    logic             out_xfer;
    logic [CNT_W-1:0] count_q, count_d;

`ifdef PIPO_PARITY_EN
    assign head_par = ^d;
`else
    assign head_par = 1'b0;
`endif

    assign stg_rdy[DEPTH] = q_ready;

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             up_valid;
        logic [WIDTH-1:0] up_data;
        logic             up_par;

        if (i == 0) begin : g_head
            assign up_valid = d_valid;
            assign up_data  = d;
            assign up_par   = head_par;
        end else begin : g_body
            assign up_valid = stg_valid[i-1];
            assign up_data  = stg_data[i-1];
            assign up_par   = stg_par[i-1];
        end

        pipo_stage #(
            .WIDTH(WIDTH)
        ) u_stage (
            .clk      (clk),
            .clr      (clr),
            .flush    (flush),
            .in_valid (up_valid),
            .in_data  (up_data),
            .in_par   (up_par),
            .out_ready(stg_rdy[i+1]),
            .valid    (stg_valid[i]),
            .data     (stg_data[i]),
            .par      (stg_par[i]),
            .in_ready (stg_rdy[i])
        );
    end

    // Refusing input during clr keeps the handshake honest: a word offered
    // while the pipe is being reset is never reported as taken.
    assign d_ready  = stg_rdy[0] && !flush && !clr;
    assign in_xfer  = d_valid && d_ready;
    assign out_xfer = v && q_ready;

    assign q     = stg_data[DEPTH-1];
    assign v     = stg_valid[DEPTH-1];
    assign q_par = stg_par[DEPTH-1];

    // Occupancy: +1 per accepted word, -1 per delivered word, cleared by flush.
    always_comb begin
        count_d = count_q;
        if (flush) begin
            count_d = '0;
        end else if (in_xfer && !out_xfer) begin
            count_d = count_q + CNT_W'(1);
        end else if (!in_xfer && out_xfer) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Occupancy register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_pipo_pipe.sv
// Directed bench for pipo_pipe: a WIDTH=4/DEPTH=4 instance and a
// WIDTH=1/DEPTH=1 instance, each checked against a word scoreboard.
// Honours PIPO_PARITY_EN for the expected q_par.
module tb_pipo_pipe;

`ifdef PIPO_PARITY_EN
    localparam bit PAR_ON = 1'b1;
`else
    localparam bit PAR_ON = 1'b0;
`endif

    logic       clk = 1'b0;

    logic       clr, d_valid, flush, q_ready;
    logic [3:0] d;
    logic       d_ready, v, q_par;
    logic [3:0] q;
    logic [2:0] count;

    logic       clr1, d_valid1, flush1, q_ready1;
    logic [0:0] d1;
    logic       d_ready1, v1, q_par1;
    logic [0:0] q1;
    logic [0:0] count1;

    int checks = 0;
    int errors = 0;

    logic [4:0] sb0 [$];
    logic [4:0] sb1 [$];

    logic       pre_rdy, pre_v, pre_par;
    logic [3:0] pre_q;
    logic       post_v, post_par;
    logic [3:0] post_q;
    logic [2:0] post_cnt;

    pipo_pipe #(.WIDTH(4), .DEPTH(4)) dut (
        .clk(clk), .clr(clr), .d(d), .d_valid(d_valid), .d_ready(d_ready),
        .flush(flush), .q(q), .v(v), .q_ready(q_ready), .count(count), .q_par(q_par)
    );

    pipo_pipe #(.WIDTH(1), .DEPTH(1)) dut1 (
        .clk(clk), .clr(clr1), .d(d1), .d_valid(d_valid1), .d_ready(d_ready1),
        .flush(flush1), .q(q1), .v(v1), .q_ready(q_ready1), .count(count1), .q_par(q_par1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected scoreboard entry {parity, data} for a word offered to a DUT.
    function automatic logic [4:0] mk(input int which, input logic [3:0] dd);
        logic [3:0] w;
        w = (which == 0) ? dd : {3'b000, dd[0]};
        return {(PAR_ON ? ^w : 1'b0), w};
    endfunction

    // One clock cycle on DUT 'which': drive, score output transfer, update model, check count.
    task automatic drive(input int which, input logic dv, input logic [3:0] dd,
                         input logic qr, input logic fl, input logic cl);
        logic       ix, ox;
        logic [4:0] e;
        bit         have;
        if (which == 0) begin
            d_valid = dv; d = dd; q_ready = qr; flush = fl; clr = cl;
        end else begin
            d_valid1 = dv; d1 = dd[0]; q_ready1 = qr; flush1 = fl; clr1 = cl;
        end
        #1;
        if (which == 0) begin
            pre_rdy = d_ready; pre_v = v; pre_q = q; pre_par = q_par;
        end else begin
            pre_rdy = d_ready1; pre_v = v1; pre_q = {3'b000, q1}; pre_par = q_par1;
        end
        ix = dv & pre_rdy;
        ox = pre_v & qr;
        if (ox === 1'b1 && !cl) begin
            have = 1'b0;
            e    = '0;
            if (which == 0 && sb0.size() > 0) begin
                e = sb0.pop_front(); have = 1'b1;
            end else if (which == 1 && sb1.size() > 0) begin
                e = sb1.pop_front(); have = 1'b1;
            end
            if (!have) begin
                chk("spurious_out", 32'(pre_v), 32'd0);
            end else begin
                chk("q_data", 32'(pre_q), 32'(e[3:0]));
                chk("q_par", 32'(pre_par), 32'(e[4]));
            end
        end
        @(posedge clk);
        if (which == 0) begin
            if (cl || fl) sb0.delete();
            else if (ix === 1'b1) sb0.push_back(mk(0, dd));
        end else begin
            if (cl || fl) sb1.delete();
            else if (ix === 1'b1) sb1.push_back(mk(1, dd));
        end
        #1;
        if (which == 0) begin
            post_v = v; post_q = q; post_par = q_par; post_cnt = count;
            chk("count", 32'(post_cnt), 32'(sb0.size()));
        end else begin
            post_v = v1; post_q = {3'b000, q1}; post_par = q_par1; post_cnt = {2'b00, count1};
            chk("count1", 32'(post_cnt), 32'(sb1.size()));
        end
        @(negedge clk);
    endtask

    initial begin
        clr = 1'b1; d = 4'hF; d_valid = 1'b1; flush = 1'b0; q_ready = 1'b1;
        clr1 = 1'b1; d1 = 1'b0; d_valid1 = 1'b0; flush1 = 1'b0; q_ready1 = 1'b0;
        @(negedge clk);

        // Reset held two cycles with a word offered
        for (int k = 0; k < 2; k++) begin
            drive(0, 1'b1, 4'hF, 1'b1, 1'b0, 1'b1);
            chk("rst_ready", 32'(pre_rdy), 32'd0);
            chk("rst_v", 32'(post_v), 32'd0);
            chk("rst_q", 32'(post_q), 32'd0);
            chk("rst_par", 32'(post_par), 32'd0);
        end

        // Back-to-back stream, no stall
        for (int i = 0; i < 4; i++) begin
            drive(0, 1'b1, 4'(i), 1'b1, 1'b0, 1'b0);
            chk("t2_ready", 32'(pre_rdy), 32'd1);
            chk("t2_v", 32'(post_v), (i == 3) ? 32'd1 : 32'd0);
        end
        chk("t2_peak", 32'(post_cnt), 32'd4);
        for (int k = 0; k < 4; k++) drive(0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("t2_empty_v", 32'(post_v), 32'd0);
        chk("t2_drained", 32'(sb0.size()), 32'd0);

        // Fill against a stalled consumer, then push and pop together
        for (int i = 1; i <= 4; i++) drive(0, 1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
        drive(0, 1'b1, 4'h5, 1'b0, 1'b0, 1'b0);
        chk("t3_full_ready", 32'(pre_rdy), 32'd0);
        chk("t3_full_cnt", 32'(post_cnt), 32'd4);
        chk("t3_full_q", 32'(post_q), 32'd1);
        drive(0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b0);
        chk("t3_pp_ready", 32'(pre_rdy), 32'd1);
        chk("t3_pp_q", 32'(pre_q), 32'd1);
        chk("t3_pp_cnt", 32'(post_cnt), 32'd4);
        for (int k = 0; k < 4; k++) drive(0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("t3_drained", 32'(sb0.size()), 32'd0);

        // Flush with three words stored and a word offered
        for (int i = 7; i <= 9; i++) drive(0, 1'b1, 4'(i), 1'b0, 1'b0, 1'b0);
        drive(0, 1'b1, 4'hA, 1'b0, 1'b1, 1'b0);
        chk("t4_ready", 32'(pre_rdy), 32'd0);
        chk("t4_v", 32'(post_v), 32'd0);
        chk("t4_cnt", 32'(post_cnt), 32'd0);
        for (int k = 0; k < 6; k++) begin
            drive(0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
            chk("t4_quiet_v", 32'(post_v), 32'd0);
        end

        // Reset while two words are in flight
        drive(0, 1'b1, 4'hC, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b1, 4'hD, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b1);
        chk("t5_cnt", 32'(post_cnt), 32'd0);
        chk("t5_v", 32'(post_v), 32'd0);
        drive(0, 1'b1, 4'h6, 1'b1, 1'b0, 1'b0);
        chk("t5_lat0", 32'(post_v), 32'd0);
        for (int k = 0; k < 3; k++) begin
            drive(0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
            chk("t5_lat", 32'(post_v), (k == 2) ? 32'd1 : 32'd0);
        end
        chk("t5_q", 32'(post_q), 32'd6);
        drive(0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("t5_drained", 32'(sb0.size()), 32'd0);

        // Parity of 4'b0111 (odd weight) and 4'b0101 (even weight)
        drive(0, 1'b1, 4'b0111, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b1, 4'b0101, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        drive(0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("t6_q0", 32'(post_q), 32'h7);
        chk("t6_par0", 32'(post_par), PAR_ON ? 32'd1 : 32'd0);
        drive(0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("t6_q1", 32'(post_q), 32'h5);
        chk("t6_par1", 32'(post_par), 32'd0);
        drive(0, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("t6_drained", 32'(sb0.size()), 32'd0);

        // Single-stage, single-bit instance: reset, stream, stall
        drive(1, 1'b1, 4'h1, 1'b1, 1'b0, 1'b1);
        chk("d1_rst_ready", 32'(pre_rdy), 32'd0);
        chk("d1_rst_v", 32'(post_v), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1, 1'b1, 4'(i & 1), 1'b1, 1'b0, 1'b0);
            chk("d1_t2_ready", 32'(pre_rdy), 32'd1);
            chk("d1_t2_v", 32'(post_v), 32'd1);
        end
        drive(1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("d1_t2_empty", 32'(post_v), 32'd0);
        drive(1, 1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        drive(1, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0);
        chk("d1_t3_ready", 32'(pre_rdy), 32'd0);
        chk("d1_t3_cnt", 32'(post_cnt), 32'd1);
        chk("d1_t3_q", 32'(post_q), 32'd1);
        drive(1, 1'b1, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("d1_t3_pp_ready", 32'(pre_rdy), 32'd1);
        chk("d1_t3_pp_cnt", 32'(post_cnt), 32'd1);
        chk("d1_t3_pp_q", 32'(post_q), 32'd0);
        drive(1, 1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("d1_drained", 32'(sb1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
